// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // request outstanding, results flow into IF/ID
    ST_HOLD    = 2'd1,  // fetched word parked in buffer while decode stalls
    ST_DISCARD = 2'd2   // wrong-path request still in flight, drop its data
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load has priority over flush; neither means hold.
import fetch_stage_pkg::*;

module ifid_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  // Register update: an invalid entry always carries a NOP so decode sees no side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/request FSM, one-entry stall buffer, redirect handling.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter int          XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] branch_target,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            misalign_err
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic [31:0]     hold_instr, hold_instr_nxt;

  logic            xfer, take;
  logic [XLEN-1:0] tgt;
  logic            ld, fl;
  logic [XLEN-1:0] ld_pc;
  logic [31:0]     ld_instr;

  // No request in HOLD, and none while reset is asserted (memory shares rst).
  assign imem_req  = !rst && (state != ST_HOLD);
  assign imem_addr = req_addr;
  assign xfer      = imem_req && imem_ready;
  // A stalled decode will present the branch again, so only act when not stalled.
  assign take      = branch_flag && ifid_valid && !stall;
  assign tgt       = align_word(branch_target);

  // State and fetch-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      req_addr   <= RESET_PC[XLEN-1:0];
      pend_pc    <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      req_addr   <= req_addr_nxt;
      pend_pc    <= pend_pc_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  // Misaligned redirect is reported one cycle after the branch is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= take && (branch_target[1:0] != 2'b00);
  end

  // Next-state, next-address and IF/ID control.
  always_comb begin
    state_nxt      = state;
    req_addr_nxt   = req_addr;
    pend_pc_nxt    = pend_pc;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    ld             = 1'b0;
    fl             = 1'b0;
    ld_pc          = req_addr;
    ld_instr       = imem_rdata;
    case (state)
      ST_FETCH: begin
        if (xfer) begin
          if (take) begin
            fl           = 1'b1;
            req_addr_nxt = tgt;
          end else if (stall) begin
            hold_pc_nxt    = req_addr;
            hold_instr_nxt = imem_rdata;
            req_addr_nxt   = req_addr + XLEN'(4);
            state_nxt      = ST_HOLD;
          end else begin
            ld           = 1'b1;
            req_addr_nxt = req_addr + XLEN'(4);
          end
        end else if (take) begin
          // Request cannot be withdrawn; remember where to go once it lands.
          pend_pc_nxt = tgt;
          fl          = 1'b1;
          state_nxt   = ST_DISCARD;
        end else if (!stall) begin
          fl = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          if (take) begin
            fl           = 1'b1;
            req_addr_nxt = tgt;
          end else begin
            ld       = 1'b1;
            ld_pc    = hold_pc;
            ld_instr = hold_instr;
          end
          state_nxt = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (!stall) fl = 1'b1;
        if (xfer) begin
          req_addr_nxt = pend_pc;
          state_nxt    = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  ifid_reg #(.XLEN(XLEN)) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .flush      (fl),
    .load_pc    (ld_pc),
    .load_instr (ld_instr),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .instr      (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, reset-in-DISCARD sequence, random run vs program-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory content is a fixed function of address so every word is recognisable.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5A3C_0000) + 32'h0000_0103;
  endfunction

  assign imem_rdata = imem_ready ? memf(imem_addr) : 32'hBAD0_BAD0;

  fetch_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .branch_flag(branch_flag), .branch_target(branch_target),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .misalign_err(misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall, ready, bflag;
    logic [31:0] btgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] t,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic em);
    vec_t v;
    v.stall = s; v.ready = r; v.bflag = b; v.btgt = t;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_mis = em;
    return v;
  endfunction

  // Model state for the random run.
  logic [31:0] exp_pc;
  logic        p_valid, p_stall, p_take, p_req, p_ready;
  logic [31:0] p_pc, p_instr, p_tgt, p_addr;
  int          consumed;

  initial begin
    //          stall rdy br  tgt           req addr          vld pc            mis
    tbl[0]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         0);
    tbl[1]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0004, 0);
    tbl[3]  = mk(0, 1, 1, 32'h0000_0100, 1, 32'h0000_000C, 1, 32'h0000_0008, 0);
    tbl[4]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0);
    tbl[5]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0104, 1, 32'h0000_0100, 0);
    tbl[6]  = mk(0, 1, 1, 32'h0000_0102, 1, 32'h0000_0108, 1, 32'h0000_0104, 0);
    tbl[7]  = mk(0, 1, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         1);
    tbl[8]  = mk(1, 1, 1, 32'h0000_0300, 1, 32'h0000_0104, 1, 32'h0000_0100, 0);
    tbl[9]  = mk(1, 1, 0, 32'h0,         0, 32'h0000_0108, 1, 32'h0000_0100, 0);
    tbl[10] = mk(0, 1, 0, 32'h0,         0, 32'h0000_0108, 1, 32'h0000_0100, 0);
    tbl[11] = mk(0, 0, 1, 32'h0000_0200, 1, 32'h0000_0108, 1, 32'h0000_0104, 0);
    tbl[12] = mk(0, 0, 0, 32'h0,         1, 32'h0000_0108, 0, 32'h0,         0);
    tbl[13] = mk(0, 1, 0, 32'h0,         1, 32'h0000_0108, 0, 32'h0,         0);
    tbl[14] = mk(0, 1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0,         0);
    tbl[15] = mk(0, 1, 0, 32'h0,         1, 32'h0000_0204, 1, 32'h0000_0200, 0);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_pc", ifid_pc, 32'h0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_mis", {31'b0, misalign_err}, 32'h0);

    // Directed table, starting the cycle reset is released.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = 1'b0;
      stall = tbl[i].stall; imem_ready = tbl[i].ready;
      branch_flag = tbl[i].bflag; branch_target = tbl[i].btgt;
      #1;
      check($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      check($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("t%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("t%0d_pc", i), ifid_pc, tbl[i].e_pc);
        check($sformatf("t%0d_instr", i), ifid_instr, memf(tbl[i].e_pc));
      end else begin
        check($sformatf("t%0d_nop", i), ifid_instr, NOP);
      end
      check($sformatf("t%0d_mis", i), {31'b0, misalign_err}, {31'b0, tbl[i].e_mis});
    end

    // Reset asserted while a redirect waits in DISCARD.
    @(negedge clk);
    stall = 0; imem_ready = 0; branch_flag = 1; branch_target = 32'h0000_0400;
    #1 check("dsc_pre_valid", {31'b0, ifid_valid}, 32'h1);
    @(negedge clk);
    branch_flag = 0;
    #1 check("dsc_valid", {31'b0, ifid_valid}, 32'h0);
    check("dsc_req", {31'b0, imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1 check("dsc_rst_req", {31'b0, imem_req}, 32'h0);
    check("dsc_rst_valid", {31'b0, ifid_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1;
    #1 check("dsc_rel_addr", imem_addr, RPC);
    check("dsc_rel_req", {31'b0, imem_req}, 32'h1);
    check("dsc_rel_valid", {31'b0, ifid_valid}, 32'h0);
    @(negedge clk);
    #1 check("dsc_first_valid", {31'b0, ifid_valid}, 32'h1);
    check("dsc_first_pc", ifid_pc, RPC);

    // Random run: instructions must reach decode in program order, each exactly once.
    @(negedge clk);
    rst = 1'b1; stall = 0; branch_flag = 0; imem_ready = 0;
    @(negedge clk);
    exp_pc = RPC; consumed = 0;
    p_valid = 0; p_stall = 0; p_take = 0; p_req = 0; p_ready = 0;
    p_pc = 0; p_instr = 0; p_tgt = 0; p_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      logic tk;
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      stall = ($urandom_range(3) == 0);
      imem_ready = ($urandom_range(2) != 0);
      branch_flag = ($urandom_range(5) == 0);
      case ($urandom_range(3))
        0: branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        1: branch_target = $urandom_range(255);
        default: branch_target = $urandom;
      endcase
      #1;
      if (p_stall) begin
        check("r_hold_valid", {31'b0, ifid_valid}, {31'b0, p_valid});
        check("r_hold_pc", ifid_pc, p_pc);
        check("r_hold_instr", ifid_instr, p_instr);
      end else if (ifid_valid) begin
        check("r_order_pc", ifid_pc, exp_pc);
      end
      if (ifid_valid) check("r_instr", ifid_instr, memf(ifid_pc));
      else            check("r_nop", ifid_instr, NOP);
      check("r_mis", {31'b0, misalign_err}, {31'b0, p_take && (p_tgt[1:0] != 2'b00)});
      if (p_req && !p_ready) begin
        check("r_req_kept", {31'b0, imem_req}, 32'h1);
        check("r_addr_kept", imem_addr, p_addr);
      end
      tk = branch_flag && ifid_valid && !stall;
      if (ifid_valid && !stall) begin
        exp_pc = tk ? {branch_target[31:2], 2'b00} : ifid_pc + 32'd4;
        consumed++;
      end
      p_valid = ifid_valid; p_pc = ifid_pc; p_instr = ifid_instr;
      p_stall = stall; p_take = tk; p_tgt = branch_target;
      p_req = imem_req; p_ready = imem_ready; p_addr = imem_addr;
    end
    checks++;
    if (consumed < 300) begin
      errors++;
      $display("FAIL r_progress: consumed %0d instructions, required at least 300", consumed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
